// File: rtl/hash_jtree_lanes.sv
// Raster sample jitter stage: per-lane, per-axis XOR-fold hash masked by MSAA
// mode, carried with triangle/colour through an elastic PIPE_DEPTH-stage pipe.
module hash_jtree_lanes #(
  parameter int SIGFIG         = 24,
  parameter int RADIX          = 10,
  parameter int VERTS          = 3,
  parameter int AXIS           = 3,
  parameter int COLORS         = 3,
  parameter int LANES          = 4,
  parameter int PIPE_DEPTH     = 2,
  parameter int HASH_OUT_WIDTH = RADIX - 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid_R14H,
  output logic                     in_ready_R14H,
  input  logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
  input  logic        [SIGFIG-1:0] color_R14U [COLORS],
  input  logic signed [SIGFIG-1:0] sample_R14S [2][LANES],
  input  logic        [LANES-1:0]  validSamp_R14H,
  input  logic        [3:0]        subSample_RnnnnU,
  input  logic                     jitter_en_RnnnnH,
  output logic                     out_valid_R16H,
  input  logic                     out_ready_R16H,
  output logic signed [SIGFIG-1:0] tri_R16S [VERTS][AXIS],
  output logic        [SIGFIG-1:0] color_R16U [COLORS],
  output logic signed [SIGFIG-1:0] sample_R16S [2][LANES],
  output logic        [LANES-1:0]  validSamp_R16H,
  output logic                     err_subsample_RnnH
);

  localparam int W  = HASH_OUT_WIDTH;
  localparam int SL = SIGFIG - 4;
  localparam int HW = 2 * SL;

  function automatic logic [W-1:0] fold_hash(input logic [HW-1:0] v);
    logic [W-1:0] h;
    h = '0;
    for (int i = 0; i < HW; i++) begin
      h[i % W] = h[i % W] ^ v[i];
    end
    return h;
  endfunction

  // Fewer jitter bits as the sample grid gets denser; illegal modes jitter nothing.
  function automatic logic [W-1:0] mode_mask(input logic [3:0] mode);
    logic [W-1:0] ones;
    logic [W-1:0] m;
    ones = '1;
    case (mode)
      4'b1000: m = ones;
      4'b0100: m = ones >> 2'd1;
      4'b0010: m = ones >> 2'd2;
      4'b0001: m = ones >> 2'd3;
      default: m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [SIGFIG-1:0] apply_jitter(input logic [SIGFIG-1:0] v,
                                                      input logic [W-1:0]      h);
    logic [SIGFIG-1:0] ext;
    ext = '0;
    ext[W-1:0] = h;
    return v | (ext << (RADIX - W));
  endfunction

  logic [W-1:0]             w_mask;
  logic signed [SIGFIG-1:0] w_samp_j [2][LANES];
  logic [PIPE_DEPTH-1:0]    w_stage_valid;
  logic [PIPE_DEPTH-1:0]    w_load;
  logic                     w_room;
  logic                     r_err;

  // Jittered sample positions for the transaction currently at the input.
  always_comb begin
    w_mask   = mode_mask(subSample_RnnnnU);
    w_samp_j = sample_R14S;
    for (int l = 0; l < LANES; l++) begin
      w_samp_j[0][l] = jitter_en_RnnnnH
        ? apply_jitter(sample_R14S[0][l],
            fold_hash({sample_R14S[1][l][SIGFIG-1:4], sample_R14S[0][l][SIGFIG-1:4]}) & w_mask)
        : sample_R14S[0][l];
      w_samp_j[1][l] = jitter_en_RnnnnH
        ? apply_jitter(sample_R14S[1][l],
            fold_hash({sample_R14S[0][l][SIGFIG-1:4], sample_R14S[1][l][SIGFIG-1:4]}) & w_mask)
        : sample_R14S[1][l];
    end
  end

  // Stage k may load when any stage from k to the tail has room or the sink drains.
  always_comb begin
    w_room = out_ready_R16H;
    w_load = '0;
    for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
      w_room    = w_room | ~w_stage_valid[k];
      w_load[k] = w_room;
    end
  end

  assign in_ready_R14H = ~rst & w_load[0];

  for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_stage
    logic                     r_valid;
    logic signed [SIGFIG-1:0] r_tri   [VERTS][AXIS];
    logic        [SIGFIG-1:0] r_color [COLORS];
    logic signed [SIGFIG-1:0] r_samp  [2][LANES];
    logic        [LANES-1:0]  r_vsamp;

    assign w_stage_valid[g] = r_valid;

    if (g == 0) begin : g_head
      // Head stage captures the incoming transaction with its jittered samples.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_valid <= 1'b0;
          r_vsamp <= '0;
          for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++) r_tri[v][a] <= '0;
          for (int c = 0; c < COLORS; c++) r_color[c] <= '0;
          for (int a = 0; a < 2; a++)
            for (int l = 0; l < LANES; l++) r_samp[a][l] <= '0;
        end else if (w_load[0]) begin
          r_valid <= in_valid_R14H;
          r_vsamp <= validSamp_R14H;
          r_tri   <= tri_R14S;
          r_color <= color_R14U;
          r_samp  <= w_samp_j;
        end
      end
    end else begin : g_body
      // Later stages shift the previous stage forward when it can advance.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_valid <= 1'b0;
          r_vsamp <= '0;
          for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++) r_tri[v][a] <= '0;
          for (int c = 0; c < COLORS; c++) r_color[c] <= '0;
          for (int a = 0; a < 2; a++)
            for (int l = 0; l < LANES; l++) r_samp[a][l] <= '0;
        end else if (w_load[g]) begin
          r_valid <= g_stage[g-1].r_valid;
          r_vsamp <= g_stage[g-1].r_vsamp;
          r_tri   <= g_stage[g-1].r_tri;
          r_color <= g_stage[g-1].r_color;
          r_samp  <= g_stage[g-1].r_samp;
        end
      end
    end
  end

  // Sticky until reset: an accepted transaction carried a non-one-hot mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (in_valid_R14H && in_ready_R14H && !$onehot(subSample_RnnnnU)) begin
      r_err <= 1'b1;
    end
  end

  assign out_valid_R16H     = g_stage[PIPE_DEPTH-1].r_valid;
  assign tri_R16S           = g_stage[PIPE_DEPTH-1].r_tri;
  assign color_R16U         = g_stage[PIPE_DEPTH-1].r_color;
  assign sample_R16S        = g_stage[PIPE_DEPTH-1].r_samp;
  assign validSamp_R16H     = g_stage[PIPE_DEPTH-1].r_vsamp;
  assign err_subsample_RnnH = r_err;

endmodule

// File: tb/tb_hash_jtree_lanes.sv
// Self-checking bench for hash_jtree_lanes: table vectors, backpressure,
// random traffic against a reference model, sticky error and reset cases.
module tb_hash_jtree_lanes;
  localparam int DEPTH = 2;
  localparam int NV    = 12;

  typedef struct packed {
    logic [8:0][23:0] tri_f;
    logic [2:0][23:0] col;
    logic [7:0][23:0] smp;
    logic [3:0]       vs;
  } txn_t;

  typedef struct packed {
    txn_t       d;
    logic [3:0] mode;
    logic       en;
  } stim_t;

  typedef struct packed {
    logic [3:0]  mode;
    logic        en;
    logic [23:0] x;
    logic [23:0] y;
    logic [23:0] ex;
    logic [23:0] ey;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, out_valid, out_ready, en_i, err;
  logic [3:0] mode_i, vs_i, vs_o;
  logic signed [23:0] tri_i [3][3];
  logic        [23:0] col_i [3];
  logic signed [23:0] smp_i [2][4];
  logic signed [23:0] tri_o [3][3];
  logic        [23:0] col_o [3];
  logic signed [23:0] smp_o [2][4];

  int   n_tests = 0, n_fail = 0, n_push = 0, n_pop = 0;
  logic stall_prev = 1'b0;
  txn_t snap, cur_exp;
  txn_t sb [$];
  vec_t tbl [NV];

  always #5 clk = ~clk;

  hash_jtree_lanes dut (
    .clk(clk), .rst(rst),
    .in_valid_R14H(in_valid), .in_ready_R14H(in_ready),
    .tri_R14S(tri_i), .color_R14U(col_i), .sample_R14S(smp_i),
    .validSamp_R14H(vs_i), .subSample_RnnnnU(mode_i), .jitter_en_RnnnnH(en_i),
    .out_valid_R16H(out_valid), .out_ready_R16H(out_ready),
    .tri_R16S(tri_o), .color_R16U(col_o), .sample_R16S(smp_o),
    .validSamp_R16H(vs_o), .err_subsample_RnnH(err)
  );

  function automatic logic [7:0] mask_of(input logic [3:0] mode);
    int n;
    case (mode)
      4'b1000: n = 8;
      4'b0100: n = 7;
      4'b0010: n = 6;
      4'b0001: n = 5;
      default: n = 0;
    endcase
    return 8'((16'd1 << n) - 16'd1);
  endfunction

  function automatic txn_t model(input stim_t s);
    txn_t r;
    logic [7:0] m, hx, hy;
    logic [39:0] vx, vy;
    logic [23:0] x, y;
    r = s.d;
    m = mask_of(s.mode);
    for (int l = 0; l < 4; l++) begin
      x  = s.d.smp[l];
      y  = s.d.smp[4+l];
      vx = {y[23:4], x[23:4]};
      vy = {x[23:4], y[23:4]};
      hx = vx[7:0] ^ vx[15:8] ^ vx[23:16] ^ vx[31:24] ^ vx[39:32];
      hy = vy[7:0] ^ vy[15:8] ^ vy[23:16] ^ vy[31:24] ^ vy[39:32];
      if (s.en) begin
        r.smp[l]   = x | {14'd0, hx & m, 2'd0};
        r.smp[4+l] = y | {14'd0, hy & m, 2'd0};
      end
    end
    return r;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    for (int i = 0; i < 9; i++) s.d.tri_f[i] = 24'($urandom);
    for (int i = 0; i < 3; i++) s.d.col[i] = 24'($urandom);
    for (int i = 0; i < 8; i++) s.d.smp[i] = 24'($urandom);
    s.d.vs = 4'($urandom_range(0, 15));
    s.mode = 4'b0001 << $urandom_range(0, 3);
    s.en   = ($urandom_range(0, 3) != 0);
    return s;
  endfunction

  function automatic txn_t get_out();
    txn_t t;
    for (int i = 0; i < 9; i++) t.tri_f[i] = tri_o[i/3][i%3];
    for (int i = 0; i < 3; i++) t.col[i] = col_o[i];
    for (int i = 0; i < 8; i++) t.smp[i] = smp_o[i/4][i%4];
    t.vs = vs_o;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_txn(input string nm, input txn_t act, input txn_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input stim_t s, input txn_t e);
    for (int i = 0; i < 9; i++) tri_i[i/3][i%3] = s.d.tri_f[i];
    for (int i = 0; i < 3; i++) col_i[i] = s.d.col[i];
    for (int i = 0; i < 8; i++) smp_i[i/4][i%4] = s.d.smp[i];
    vs_i    = s.d.vs;
    mode_i  = s.mode;
    en_i    = s.en;
    cur_exp = e;
  endtask

  // One cycle: observe at the falling edge (scoreboard, stall stability), then step.
  task automatic tick();
    txn_t act, ex;
    @(negedge clk);
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      act = get_out();
      if (stall_prev) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk_txn("stall_hold", act, snap);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got %h with empty scoreboard", act);
        end else begin
          ex = sb.pop_front();
          chk_txn("out_data", act, ex);
        end
        n_pop++;
      end
      stall_prev = out_valid && !out_ready;
      snap       = act;
      if (in_valid && in_ready) begin
        sb.push_back(cur_exp);
        n_push++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic lat_test(input stim_t s, input txn_t e);
    int lat;
    drive(s, e);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk("latency", 64'(lat), 64'(DEPTH));
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    stim_t s;
    txn_t  e, zero_t;
    int    target, cyc, np0;
    zero_t = '0;
    tbl[0]  = '{4'b1000, 1'b1, 24'h000400, 24'h000000, 24'h000500, 24'h000010};
    tbl[1]  = '{4'b0001, 1'b1, 24'h000400, 24'h000000, 24'h000400, 24'h000010};
    tbl[2]  = '{4'b1000, 1'b0, 24'h000400, 24'h000000, 24'h000400, 24'h000000};
    tbl[3]  = '{4'b0100, 1'b1, 24'h000400, 24'h000000, 24'h000500, 24'h000010};
    tbl[4]  = '{4'b0010, 1'b1, 24'h000400, 24'h000000, 24'h000400, 24'h000010};
    tbl[5]  = '{4'b1000, 1'b1, 24'h000010, 24'h000000, 24'h000014, 24'h000040};
    tbl[6]  = '{4'b1000, 1'b1, 24'h000010, 24'h000010, 24'h000054, 24'h000054};
    tbl[7]  = '{4'b1000, 1'b1, 24'h001010, 24'h000000, 24'h001010, 24'h000000};
    tbl[8]  = '{4'b1000, 1'b1, 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h0003C0};
    tbl[9]  = '{4'b1000, 1'b1, 24'h00000F, 24'h000000, 24'h00000F, 24'h000000};
    tbl[10] = '{4'b1000, 1'b1, 24'h000000, 24'h000040, 24'h000100, 24'h000050};
    tbl[11] = '{4'b0010, 1'b1, 24'h000000, 24'h000040, 24'h000000, 24'h000050};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    drive('0, '0);
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk_txn("rst_data", get_out(), zero_t);
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      s = rand_stim();
      s.mode = tbl[i].mode;
      s.en   = tbl[i].en;
      for (int l = 0; l < 8; l++) s.d.smp[l] = '0;
      s.d.smp[0] = tbl[i].x;
      s.d.smp[4] = tbl[i].y;
      e = s.d;
      e.smp[0] = tbl[i].ex;
      e.smp[4] = tbl[i].ey;
      lat_test(s, e);
    end

    // Backpressure: two fill the pipe, the third waits for the first to leave.
    out_ready = 1'b0;
    s = rand_stim();
    drive(s, model(s));
    in_valid = 1'b1;
    tick();
    chk("bp_ready1", 64'(in_ready), 64'd1);
    s = rand_stim();
    drive(s, model(s));
    tick();
    s = rand_stim();
    s.d.vs = 4'b0000;
    drive(s, model(s));
    chk("bp_full", 64'(in_ready), 64'd0);
    tick();
    chk("bp_still_full", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_release", 64'(in_ready), 64'd1);
    np0 = n_pop;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("bp_three_out", 64'(n_pop - np0), 64'd3);
    drain();

    target = n_push + 10000;
    cyc = 0;
    while (n_push < target && cyc < 40000) begin
      s = rand_stim();
      drive(s, model(s));
      in_valid  = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
      cyc++;
    end
    chk("random_count", 64'(n_push >= target), 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    chk("err_before", 64'(err), 64'd0);
    s = rand_stim();
    s.mode = 4'b0011;
    s.en   = 1'b1;
    for (int l = 0; l < 8; l++) s.d.smp[l] = '0;
    s.d.smp[0] = 24'h000400;
    e = s.d;
    lat_test(s, e);
    chk("err_set", 64'(err), 64'd1);
    s = rand_stim();
    lat_test(s, model(s));
    chk("err_sticky", 64'(err), 64'd1);

    // Reset with two transactions in flight.
    out_ready = 1'b0;
    s = rand_stim();
    drive(s, model(s));
    in_valid = 1'b1;
    tick();
    s = rand_stim();
    drive(s, model(s));
    tick();
    in_valid = 1'b0;
    chk("inflight_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    chk_txn("mid_rst_data", get_out(), zero_t);
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
    s = rand_stim();
    lat_test(s, model(s));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
